cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
- Backing-memory responder on the miss side of the direct-mapped cache.
- The cache issues word read (refill) or write requests over a valid/ready request channel.
- The block models a fixed-latency word memory and returns one response per request over a valid/ready response channel.
- Serves as the memory model for cache verification and as the memory-side endpoint in the cache subsystem.

Parameters:
- DEPTH, 256, number of 32-bit words stored; power of two, 8..4096.
- LATENCY, 4, cycles from request acceptance to rsp_valid assertion; 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_addr  input  32  byte address
- req_we  input  1  1 = write, 0 = read
- req_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_data  output  32  read data; 0 for writes and errors
- rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state updates occur on the clk rising edge.
- Reset values:
  - req_ready=0 during reset, 1 in the first cycle after reset.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - FSM=IDLE, latency counter=0.
  - Memory array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch addr/we/wdata.
    - If LATENCY==1, go to RESP; otherwise go to BUSY with cnt=LATENCY-2.
  - BUSY: req_ready=0. Decrement cnt each cycle. When cnt==0, perform the access and go to RESP on the next edge.
  - RESP: rsp_valid=1. rsp_data and rsp_err are stable until the handshake. On rsp_ready, go to IDLE (req_ready=1 the next cycle).
- Latency: for a request accepted at edge T, rsp_valid is first high in the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance when rsp_ready is held high.
- Throughput: one outstanding transaction; no pipelining.
- Accesses:
  - Word index = (req_addr-BASE_ADDR)>>2.
  - Read returns mem[index].
  - Write commits mem[index]=wdata at the edge that enters RESP; rsp_data=0.
- Errors:
  - Error if req_addr[1:0]!=0, req_addr<BASE_ADDR, or index>=DEPTH.
  - On error: rsp_err=1, rsp_data=0, no memory write. The response is still returned after LATENCY cycles.
- Flow control:
  - req_valid while not ready is ignored; the requester must hold it.
  - req_addr/we/wdata are sampled only at acceptance, so later changes have no effect.
  - rsp_valid stays high indefinitely under rsp_ready=0 backpressure; outputs are held.
- Simultaneous events: in RESP, rsp handshake and a new req_valid in the same cycle — the new request is not accepted until IDLE (one bubble cycle).
- Reset mid-operation: a transaction in BUSY or RESP is dropped. A write is not committed unless the commit edge has already passed. Outputs return to reset values.
- Counter: 4 bits, never wraps (bounded by LATENCY≤15).

Decomposition:
- Shared package cache_pkg:
  - ADDR_W=32, DATA_W=32, OFFSET_W=2.
  - State encoding constants (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
  - Error-code constant.
  - Later reused by direct_cache for its miss interface.
- Sub-module cache_mem_sram: single-port synchronous word RAM with parameters DEPTH and DATA_W, and ports en, we, addr, wdata, rdata (one-cycle read).
  - The responder issues the RAM access in the final BUSY cycle (or the accept cycle when LATENCY==1) so that rdata is valid on entering RESP.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
- Write/read round trip, LATENCY=4:
  - Write 0x0000_0010 with 0xDEAD_BEEF -> rsp_valid exactly 4 cycles after acceptance, rsp_data=0, rsp_err=0.
  - Read 0x10 -> rsp_data=0xDEAD_BEEF after 4 cycles.
- Errors:
  - Read 0x0000_0013 -> rsp_err=1, rsp_data=0.
  - Write 0x400 (index 256, DEPTH=256) -> rsp_err=1, and a read of 0x0 is unchanged.
- Backpressure: rsp_ready=0 for 10 cycles on a read of 0x10 -> rsp_valid and rsp_data=0xDEAD_BEEF held stable, req_ready=0 throughout; handshake -> req_ready=1 next cycle.
- LATENCY=1 build: back-to-back reads of 0x0 and 0x4 with rsp_ready=1 -> each response 1 cycle after acceptance, one bubble between transactions.
- Reset mid-BUSY: write 0x20=0x1234_5678, assert rst_n=0 two cycles after acceptance (LATENCY=4) -> no response; a subsequent read of 0x20 returns its prior value.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache subsystem memory side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: bus widths, responder FSM state encoding, response error codes.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int OFFSET_W = 2;   // byte offset bits within a 32-bit word

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Response error code carried on rsp_err.
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_ADDR = 1'b1;  // misaligned or out-of-range address

endpackage

// File: rtl/cache_mem_sram.sv
// Single-port synchronous word RAM.
// Latency: read data registered, valid the cycle after i_en with i_we=0.
// Backpressure: none; o_rdata holds its last read value while i_en=0.
// Ports: i_clk, i_en (access strobe), i_we (1=write), i_addr (word index),
//        i_wdata (write data), o_rdata (registered read data). Not reset.
module cache_mem_sram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency word memory answering cache refill/write requests.
// Latency: response valid LATENCY cycles after request acceptance; one outstanding.
// Backpressure: response held stable while i_rsp_ready=0; no new request until handshake.
// Ports: i_clk, i_rst_n (sync, active-low); request channel i_req_valid/o_req_ready
//        with i_req_addr, i_req_we, i_req_wdata; response channel o_rsp_valid/i_rsp_ready
//        with o_rsp_data (0 for writes and errors) and o_rsp_err.
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int                DEPTH     = 256,
    parameter int                LATENCY   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_we,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         WIDX_W   = ADDR_W - OFFSET_W;
    // BUSY counts down from LATENCY-2 so the last BUSY cycle (cnt==0) is the
    // one that issues the RAM access, landing RESP exactly LATENCY cycles out.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_ready_en;   // low through reset, high from the first cycle after
    logic                r_we;
    logic                r_err;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_offs;
    logic                w_err_in;
    logic [IDX_W-1:0]    w_idx_in;

    logic                w_ram_en;
    logic                w_ram_we;
    logic [IDX_W-1:0]    w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_ram_rdata;

    // Address decode on the live request; only meaningful at acceptance.
    assign w_offs   = i_req_addr - BASE_ADDR;
    assign w_err_in = (i_req_addr[OFFSET_W-1:0] != '0) ||
                      (i_req_addr < BASE_ADDR) ||
                      (w_offs[ADDR_W-1:OFFSET_W] >= WIDX_W'(DEPTH));
    assign w_idx_in = w_offs[OFFSET_W +: IDX_W];

    // State and request capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_ready_en <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= ERR_NONE;
            r_idx      <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_we    <= i_req_we;
                r_err   <= w_err_in ? ERR_ADDR : ERR_NONE;
                r_idx   <= w_idx_in;
                r_wdata <= i_req_wdata;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = r_ready_en;
                w_accept    = i_req_valid && r_ready_en;
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // RAM access issue: the cycle before RESP, so a write commits on the edge
    // entering RESP and read data is registered by then. With LATENCY==1 that
    // cycle is the accept cycle, so the live request drives the RAM directly.
    // Gating with i_rst_n drops the access if reset lands before the commit edge.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (LATENCY == 1) begin
            w_ram_en    = w_accept && !w_err_in;
            w_ram_we    = i_req_we;
            w_ram_addr  = w_idx_in;
            w_ram_wdata = i_req_wdata;
        end else begin
            w_ram_en    = (r_state == ST_BUSY) && (r_cnt == 4'd0) && (r_err == ERR_NONE);
            w_ram_we    = r_we;
            w_ram_addr  = r_idx;
            w_ram_wdata = r_wdata;
        end
        w_ram_en = w_ram_en && i_rst_n;
    end

    cache_mem_sram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .i_clk   (i_clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM output register is untouched during RESP, so data stays stable under backpressure.
    assign o_rsp_err  = (r_state == ST_RESP) && (r_err == ERR_ADDR);
    assign o_rsp_data = ((r_state == ST_RESP) && (r_err == ERR_NONE) && !r_we) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized self-checking bench for cache_mem_responder (LATENCY=4 and LATENCY=1 builds).
// Latency: checks response arrives exactly LATENCY cycles after acceptance.
// Backpressure: holds rsp_ready low for random spans and checks the response stays put.
module tb_cache_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT [2] = '{4, 1};

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_we    [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];

    // Reference memory contents per instance, updated only on committed writes.
    logic [31:0] mdl [2][DEPTH];

    int n_total = 0;
    int n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_mem_responder #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(32'h0)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_addr(req_addr[0]), .i_req_we(req_we[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0])
    );

    cache_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_addr(req_addr[1]), .i_req_we(req_we[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction on instance d, with bp cycles of response backpressure.
    task automatic txn(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input int bp);
        bit          ok;
        int          lat;
        logic        e;
        logic [31:0] ed;
        int          idx;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        check("req_ready_wait", 32'(ok), 32'd1);
        if (!ok) return;
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_we[d]    = w;
        req_wdata[d] = wd;
        rsp_ready[d] = (bp == 0);
        @(posedge clk);
        #1;
        // Scramble the request fields: only the accepted values may matter.
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_we[d]    = 1'($urandom);
        req_wdata[d] = $urandom;

        e   = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        idx = int'(a >> 2);
        ed  = (e || w) ? 32'h0 : mdl[d][idx];
        if (!e && w) mdl[d][idx] = wd;

        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[d]) begin
                ok = 1'b1;
                break;
            end
            check("busy_req_ready", 32'(req_ready[d]), 32'd0);
        end
        check("rsp_latency", 32'(lat), 32'(LAT[d]));
        if (!ok) return;
        check("rsp_data", rsp_data[d], ed);
        check("rsp_err", 32'(rsp_err[d]), 32'(e));
        check("resp_req_ready", 32'(req_ready[d]), 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid[d]), 32'd1);
            check("bp_data", rsp_data[d], ed);
            check("bp_err", 32'(rsp_err[d]), 32'(e));
            check("bp_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        check("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
        check("post_hs_valid", 32'(rsp_valid[d]), 32'd0);
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bit          got_rsp;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = 32'h0;
            req_we[d]    = 1'b0;
            req_wdata[d] = 32'h0;
            rsp_ready[d] = 1'b0;
        end

        // Reset and idle.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rsp_data", rsp_data[d], 32'h0);
            check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("idle_req_ready", 32'(req_ready[d]), 32'd1);
            check("idle_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("idle_rsp_data", rsp_data[d], 32'h0);
            check("idle_rsp_err", 32'(rsp_err[d]), 32'd0);
        end

        // Give every word a known value in both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                txn(d, 32'(i * 4), 1'b1, $urandom, 0);
            end
        end

        // Directed: write/read round trip, errors, backpressure.
        txn(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0);
        txn(0, 32'h0000_0010, 1'b0, 32'h0, 0);
        check("roundtrip_model", mdl[0][4], 32'hDEAD_BEEF);
        txn(0, 32'h0000_0013, 1'b0, 32'h0, 0);
        txn(0, 32'h0000_0400, 1'b1, 32'hCAFE_F00D, 0);
        txn(0, 32'h0000_0000, 1'b0, 32'h0, 0);
        txn(0, 32'h0000_0010, 1'b0, 32'h0, 10);

        // LATENCY=1: back-to-back reads with req_valid held, one bubble between.
        @(negedge clk);
        check("l1_ready0", 32'(req_ready[1]), 32'd1);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h0;
        req_we[1]    = 1'b0;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("l1_rsp0_valid", 32'(rsp_valid[1]), 32'd1);
        check("l1_rsp0_data", rsp_data[1], mdl[1][0]);
        check("l1_rsp0_ready", 32'(req_ready[1]), 32'd0);
        req_addr[1] = 32'h4;
        @(negedge clk);
        check("l1_bubble_valid", 32'(rsp_valid[1]), 32'd0);
        check("l1_bubble_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        check("l1_rsp1_valid", 32'(rsp_valid[1]), 32'd1);
        check("l1_rsp1_data", rsp_data[1], mdl[1][1]);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("l1_after_valid", 32'(rsp_valid[1]), 32'd0);
        rsp_ready[1] = 1'b0;

        // Reset while BUSY: write to 0x20 must be dropped.
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready[0]), 32'd1);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_we[0]    = 1'b1;
        req_wdata[0] = 32'h1234_5678;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        got_rsp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0]) got_rsp = 1'b1;
        end
        check("mid_rst_req_ready", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[0]) got_rsp = 1'b1;
        end
        check("mid_rst_no_rsp", 32'(got_rsp), 32'd0);
        rsp_ready[0] = 1'b0;
        txn(0, 32'h20, 1'b0, 32'h0, 0);

        // Random traffic on both instances.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                1:       a = 32'h400 + (32'($urandom_range(0, 1023)) << 2);
                default: a = 32'($urandom_range(0, 255)) << 2;
            endcase
            txn(int'($urandom_range(0, 1)), a, 1'($urandom), $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
